// File: rtl/ex_mdu.sv
// ex_mdu -- multi-cycle multiply/divide unit for the EX stage.
//
// Owns the architectural HI/LO registers. mult/multu/div/divu compute into a
// shadow {SHI,SLO} at issue and hold Busy for a fixed number of cycles; HI/LO
// take the shadow value on the edge that ends the last Busy cycle. mthi/mtlo
// write HI/LO directly at issue and never raise Busy.
//
// Optional feature: define MDU_MADD_EN to enable madd/maddu/msub/msubu
// (MDOp 0111..1010), which accumulate the product into {HI,LO}. Without the
// macro those codes are nops and no accumulator adder exists.
//
// Parameters:
//   MULT_CYCLES  Busy cycles for the multiply family (1..31)
//   DIV_CYCLES   Busy cycles for div/divu (1..31)
// Ports:
//   clk     in   system clock, rising edge
//   reset   in   synchronous active-high reset
//   A, B    in   forwarded rs/rt operands (32 bits)
//   MDOp    in   operation select (4 bits)
//   Start   in   issue MDOp this cycle
//   IntReq  in   exception/interrupt this cycle, suppresses issue
//   Busy    out  operation in progress (drives ID stall)
//   HI, LO  out  architectural HI/LO registers
module ex_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  MDOp,
  input  logic        Start,
  input  logic        IntReq,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [3:0] OP_MULT  = 4'b0001;
  localparam logic [3:0] OP_MULTU = 4'b0010;
  localparam logic [3:0] OP_DIV   = 4'b0011;
  localparam logic [3:0] OP_DIVU  = 4'b0100;
  localparam logic [3:0] OP_MTHI  = 4'b0101;
  localparam logic [3:0] OP_MTLO  = 4'b0110;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'b0111;
  localparam logic [3:0] OP_MADDU = 4'b1000;
  localparam logic [3:0] OP_MSUB  = 4'b1001;
  localparam logic [3:0] OP_MSUBU = 4'b1010;
`endif

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [4:0]         r_cnt;
  logic [31:0]        r_hi;
  logic [31:0]        r_lo;
  logic [31:0]        r_shi;
  logic [31:0]        r_slo;

  logic               w_issue;
  logic               w_long;
  logic               w_is_div;
  logic [63:0]        w_res;
  logic [4:0]         w_cnt_load;
  logic signed [63:0] w_prod_s;
  logic [63:0]        w_prod_u;

  // Signed divide returning {remainder, quotient}. Zero divisor and the single
  // overflow case are pinned explicitly rather than left to operator semantics.
  function automatic logic [63:0] f_div_s(input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] q;
    logic signed [31:0] r;
    if (b == 32'd0) begin
      return {a, 32'hFFFF_FFFF};
    end
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      return {32'd0, 32'h8000_0000};
    end
    q = $signed(a) / $signed(b);
    r = $signed(a) % $signed(b);
    return {r, q};
  endfunction

  function automatic logic [63:0] f_div_u(input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) begin
      return {a, 32'hFFFF_FFFF};
    end
    return {a % b, a / b};
  endfunction

  assign w_issue    = Start && !IntReq && (r_state == S_IDLE);
  assign w_prod_s   = $signed(A) * $signed(B);
  assign w_prod_u   = {32'd0, A} * {32'd0, B};
  assign w_cnt_load = w_is_div ? 5'(DIV_CYCLES) : 5'(MULT_CYCLES);

  // Operation decode and shadow result
  always_comb begin
    w_long   = 1'b0;
    w_is_div = 1'b0;
    w_res    = 64'd0;
    case (MDOp)
      OP_MULT:  begin w_long = 1'b1; w_res = w_prod_s; end
      OP_MULTU: begin w_long = 1'b1; w_res = w_prod_u; end
      OP_DIV:   begin w_long = 1'b1; w_is_div = 1'b1; w_res = f_div_s(A, B); end
      OP_DIVU:  begin w_long = 1'b1; w_is_div = 1'b1; w_res = f_div_u(A, B); end
`ifdef MDU_MADD_EN
      // Accumulate base is HI/LO as they stand at the issue edge.
      OP_MADD:  begin w_long = 1'b1; w_res = {r_hi, r_lo} + w_prod_s; end
      OP_MADDU: begin w_long = 1'b1; w_res = {r_hi, r_lo} + w_prod_u; end
      OP_MSUB:  begin w_long = 1'b1; w_res = {r_hi, r_lo} - w_prod_s; end
      OP_MSUBU: begin w_long = 1'b1; w_res = {r_hi, r_lo} - w_prod_u; end
`else
      // Codes 0111..1010 fall through to the nop default.
`endif
      default: ;
    endcase
  end

  // FSM next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_issue && w_long) w_state_nxt = S_RUN;
      S_RUN:  if (r_cnt == 5'd1)     w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // HI/LO, shadow and counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= 5'd0;
      r_hi  <= 32'd0;
      r_lo  <= 32'd0;
      r_shi <= 32'd0;
      r_slo <= 32'd0;
    end else if (r_state == S_IDLE) begin
      if (w_issue) begin
        if (MDOp == OP_MTHI) r_hi <= A;
        if (MDOp == OP_MTLO) r_lo <= A;
        if (w_long) begin
          r_shi <= w_res[63:32];
          r_slo <= w_res[31:0];
          r_cnt <= w_cnt_load;
        end
      end
    end else begin
      r_cnt <= r_cnt - 5'd1;
      if (r_cnt == 5'd1) begin
        r_hi <= r_shi;
        r_lo <= r_slo;
      end
    end
  end

  assign Busy = (r_state == S_RUN);
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule

// File: tb/tb_ex_mdu.sv
// Testbench for ex_mdu: directed vectors plus randomized operations checked
// against an arithmetic reference model of HI/LO and operation latency.
module tb_ex_mdu;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  MDOp;
  logic        Start;
  logic        IntReq;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  ex_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .MDOp(MDOp), .Start(Start),
    .IntReq(IntReq), .Busy(Busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  // Reference model: updates m_hi/m_lo as the architecture should end up,
  // returns the number of Busy cycles the operation must take.
  function automatic int model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sp;
    longint      la;
    longint      lb;
    longint      q;
    longint      r;
    logic [63:0] up;
    logic [63:0] acc;
    sp  = longint'($signed(a)) * longint'($signed(b));
    up  = 64'(a) * 64'(b);
    acc = {m_hi, m_lo};
    case (op)
      4'd1: begin {m_hi, m_lo} = sp; return MC; end
      4'd2: begin {m_hi, m_lo} = up; return MC; end
      4'd3: begin
        if (b == 32'd0) begin m_hi = a; m_lo = 32'hFFFF_FFFF; end
        else begin
          la = longint'($signed(a)); lb = longint'($signed(b));
          q = la / lb; r = la - q * lb;
          m_lo = q[31:0]; m_hi = r[31:0];
        end
        return DC;
      end
      4'd4: begin
        if (b == 32'd0) begin m_hi = a; m_lo = 32'hFFFF_FFFF; end
        else begin
          la = longint'(a); lb = longint'(b);
          q = la / lb; r = la - q * lb;
          m_lo = q[31:0]; m_hi = r[31:0];
        end
        return DC;
      end
      4'd5: begin m_hi = a; return 0; end
      4'd6: begin m_lo = a; return 0; end
`ifdef MDU_MADD_EN
      4'd7:  begin {m_hi, m_lo} = acc + sp; return MC; end
      4'd8:  begin {m_hi, m_lo} = acc + up; return MC; end
      4'd9:  begin {m_hi, m_lo} = acc - sp; return MC; end
      4'd10: begin {m_hi, m_lo} = acc - up; return MC; end
`endif
      default: return 0;
    endcase
  endfunction

  // Issues one op and measures Busy; held reports whether HI/LO stayed at
  // old_hi/old_lo for every Busy cycle.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] old_hi, input logic [31:0] old_lo,
                       output int cyc, output bit held);
    @(negedge clk);
    A = a; B = b; MDOp = op; Start = 1'b1; IntReq = 1'b0;
    @(negedge clk);
    Start = 1'b0;
    cyc = 0;
    held = 1'b1;
    while (Busy === 1'b1 && cyc < 64) begin
      if (HI !== old_hi || LO !== old_lo) held = 1'b0;
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; Start = 1'b0; IntReq = 1'b0; A = '0; B = '0; MDOp = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    m_hi = 32'd0; m_lo = 32'd0;
    n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", Busy); end
    n_cmp++; if (HI !== 32'd0) begin n_err++; $display("FAIL reset_hi: got %h expected 00000000", HI); end
    n_cmp++; if (LO !== 32'd0) begin n_err++; $display("FAIL reset_lo: got %h expected 00000000", LO); end
  endtask

  // One operation checked against the model; lit_* add literal expectations.
  task automatic test_arith(input string name, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, input bit use_lit,
                            input logic [31:0] lit_hi, input logic [31:0] lit_lo);
    logic [31:0] oh;
    logic [31:0] ol;
    int          exp_n;
    int          cyc;
    bit          held;
    oh = m_hi; ol = m_lo;
    exp_n = model_op(op, a, b);
    do_op(op, a, b, oh, ol, cyc, held);
    n_cmp++; if (cyc != exp_n) begin n_err++; $display("FAIL %s_latency: got %0d busy cycles expected %0d", name, cyc, exp_n); end
    if (exp_n > 0) begin
      n_cmp++; if (!held) begin n_err++; $display("FAIL %s_hold: HI/LO changed during Busy, expected %h/%h held", name, oh, ol); end
    end
    n_cmp++; if (HI !== m_hi || LO !== m_lo) begin n_err++; $display("FAIL %s_result: got HI=%h LO=%h expected HI=%h LO=%h", name, HI, LO, m_hi, m_lo); end
    if (use_lit) begin
      n_cmp++; if (HI !== lit_hi || LO !== lit_lo) begin n_err++; $display("FAIL %s_literal: got HI=%h LO=%h expected HI=%h LO=%h", name, HI, LO, lit_hi, lit_lo); end
    end
  endtask

  task automatic test_directed();
    test_arith("mult",     4'd1, 32'hFFFF_FFFE, 32'd3,        1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    test_arith("multu",    4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001);
    test_arith("div",      4'd3, 32'hFFFF_FFF9, 32'd2,        1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    test_arith("divu_zero",4'd4, 32'd7,         32'd0,        1'b1, 32'h0000_0007, 32'hFFFF_FFFF);
    test_arith("div_zero", 4'd3, 32'h8000_0001, 32'd0,        1'b1, 32'h8000_0001, 32'hFFFF_FFFF);
    test_arith("div_ovf",  4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 32'h8000_0000);
    test_arith("mtlo",     4'd6, 32'h1234_5678, 32'd0,        1'b1, 32'h0000_0000, 32'h1234_5678);
  endtask

  task automatic test_intreq();
    logic [31:0] oh;
    logic [31:0] ol;
    bit          ok;
    oh = m_hi; ol = m_lo;
    @(negedge clk);
    A = ~oh; MDOp = 4'd5; Start = 1'b1; IntReq = 1'b1;
    @(negedge clk);
    Start = 1'b0; IntReq = 1'b0;
    n_cmp++; if (HI !== oh || Busy !== 1'b0) begin n_err++; $display("FAIL intreq_mthi: got HI=%h Busy=%b expected HI=%h Busy=0", HI, Busy, oh); end
    @(negedge clk);
    A = 32'd9; B = 32'd9; MDOp = 4'd1; Start = 1'b1; IntReq = 1'b1;
    @(negedge clk);
    Start = 1'b0; IntReq = 1'b0;
    ok = 1'b1;
    repeat (MC + 2) begin
      if (Busy !== 1'b0 || HI !== oh || LO !== ol) ok = 1'b0;
      @(negedge clk);
    end
    n_cmp++; if (!ok) begin n_err++; $display("FAIL intreq_mult: got HI=%h LO=%h Busy=%b expected HI=%h LO=%h Busy=0", HI, LO, Busy, oh, ol); end
  endtask

  // Start held (with IntReq toggling) through the whole Busy window.
  task automatic test_busy_ignore();
    logic [31:0] a;
    logic [31:0] b;
    int          cyc;
    a = $urandom; b = $urandom;
    void'(model_op(4'd1, a, b));
    @(negedge clk);
    A = a; B = b; MDOp = 4'd1; Start = 1'b1; IntReq = 1'b0;
    @(negedge clk);
    A = ~a; B = b + 32'd1;
    cyc = 0;
    while (Busy === 1'b1 && cyc < 64) begin
      cyc++;
      IntReq = cyc[0];
      MDOp = cyc[1] ? 4'd5 : 4'd1;
      if (cyc >= MC) Start = 1'b0;
      @(negedge clk);
    end
    Start = 1'b0; IntReq = 1'b0;
    n_cmp++; if (cyc != MC) begin n_err++; $display("FAIL busy_ignore_latency: got %0d expected %0d", cyc, MC); end
    n_cmp++; if (HI !== m_hi || LO !== m_lo) begin n_err++; $display("FAIL busy_ignore_result: got HI=%h LO=%h expected HI=%h LO=%h", HI, LO, m_hi, m_lo); end
    @(negedge clk);
    n_cmp++; if (Busy !== 1'b0 || HI !== m_hi || LO !== m_lo) begin n_err++; $display("FAIL busy_ignore_after: got HI=%h LO=%h Busy=%b expected HI=%h LO=%h Busy=0", HI, LO, Busy, m_hi, m_lo); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    test_arith("pre_mthi", 4'd5, 32'hA5A5_0001, 32'd0, 1'b0, 32'd0, 32'd0);
    test_arith("pre_mtlo", 4'd6, 32'h5A5A_0002, 32'd0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    A = 32'd100; B = 32'd7; MDOp = 4'd3; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    n_cmp++; if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin n_err++; $display("FAIL reset_mid: got HI=%h LO=%h Busy=%b expected 0/0/0", HI, LO, Busy); end
    ok = 1'b1;
    repeat (DC + 4) begin
      @(negedge clk);
      if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) ok = 1'b0;
    end
    n_cmp++; if (!ok) begin n_err++; $display("FAIL reset_mid_no_commit: got HI=%h LO=%h Busy=%b expected 0/0/0", HI, LO, Busy); end
  endtask

  task automatic test_random();
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: b = 32'($urandom_range(1, 20));
        default: ;
      endcase
      test_arith("random", op, a, b, 1'b0, 32'd0, 32'd0);
    end
  endtask

`ifdef MDU_MADD_EN
  task automatic test_madd();
    test_arith("madd_pre_hi", 4'd5, 32'd0,         32'd0, 1'b0, 32'd0, 32'd0);
    test_arith("madd_pre_lo", 4'd6, 32'hFFFF_FFFF, 32'd0, 1'b0, 32'd0, 32'd0);
    test_arith("madd",  4'd7,  32'd1, 32'd1, 1'b1, 32'h0000_0001, 32'h0000_0000);
    test_arith("msubu", 4'd10, 32'd1, 32'd1, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF);
    test_arith("msub",  4'd9,  32'hFFFF_FFFF, 32'd3, 1'b0, 32'd0, 32'd0);
    test_arith("maddu", 4'd8,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'd0);
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_intreq();
    test_busy_ignore();
    test_reset_mid();
`ifdef MDU_MADD_EN
    test_madd();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
